// File: rtl/led_frame_smoother.sv
// Temporal smoother between the visualizer and LEDDriver2: instant attack, shift decay
// per 8-bit colour field and per LED count, published through the driver start/done handshake.
module led_frame_smoother #(
  parameter int BIN_QTY     = 12,
  parameter int LEDS        = 50,
  parameter int DECAY_SHIFT = 2,
  localparam int CW         = $clog2(LEDS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BIN_QTY*24-1:0]   rgbIn,
  input  logic [BIN_QTY*CW-1:0]   LEDCountsIn,
  input  logic                    inValid,
  input  logic                    ldDone,
  output logic [BIN_QTY*24-1:0]   rgb,
  output logic [BIN_QTY*CW-1:0]   LEDCounts,
  output logic                    start,
  output logic                    frameDropped
);

  localparam int BW = (BIN_QTY > 1) ? $clog2(BIN_QTY) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FILTER  = 2'd1;
  localparam logic [1:0] S_PUBLISH = 2'd2;
  localparam logic [1:0] S_HANDOFF = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [BW-1:0]           bin_q, bin_d;
  logic [BIN_QTY*24-1:0]   in_rgb_q, in_rgb_d;
  logic [BIN_QTY*CW-1:0]   in_cnt_q, in_cnt_d;
  logic [BIN_QTY*24-1:0]   work_rgb_q, work_rgb_d;
  logic [BIN_QTY*CW-1:0]   work_cnt_q, work_cnt_d;
  logic [BIN_QTY*24-1:0]   rgb_q, rgb_d;
  logic [BIN_QTY*CW-1:0]   cnt_q, cnt_d;
  logic                    start_q, start_d;
  logic                    drop_q, drop_d;

  int                      idx;
  logic [23:0]             old_px, new_px;
  logic [CW-1:0]           old_c, new_c;

  // Falling values step by (old-new)>>DECAY_SHIFT, never less than 1, so they always converge.
  function automatic logic [7:0] smooth8(input logic [7:0] old_v, input logic [7:0] new_v);
    logic [7:0] d;
    logic [7:0] s;
    if (new_v >= old_v) return new_v;
    d = old_v - new_v;
    s = d >> DECAY_SHIFT;
    if (s == 8'd0) s = 8'd1;
    return old_v - s;
  endfunction

  function automatic logic [CW-1:0] smooth_cnt(input logic [CW-1:0] old_v,
                                               input logic [CW-1:0] new_v);
    logic [CW-1:0] d;
    logic [CW-1:0] s;
    if (new_v >= old_v) return new_v;
    d = old_v - new_v;
    s = d >> DECAY_SHIFT;
    if (s == '0) s = CW'(1);
    return old_v - s;
  endfunction

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    in_rgb_d   = in_rgb_q;
    in_cnt_d   = in_cnt_q;
    work_rgb_d = work_rgb_q;
    work_cnt_d = work_cnt_q;
    rgb_d      = rgb_q;
    cnt_d      = cnt_q;
    start_d    = start_q;
    drop_d     = 1'b0;
    idx        = int'(bin_q);
    old_px     = work_rgb_q[idx*24 +: 24];
    new_px     = in_rgb_q[idx*24 +: 24];
    old_c      = work_cnt_q[idx*CW +: CW];
    new_c      = in_cnt_q[idx*CW +: CW];

    case (state_q)
      S_IDLE: begin
        if (inValid) begin
          in_rgb_d = rgbIn;
          in_cnt_d = LEDCountsIn;
          bin_d    = '0;
          state_d  = S_FILTER;
        end
      end
      S_FILTER: begin
        drop_d = inValid;
        work_rgb_d[idx*24 +: 24] = {smooth8(old_px[23:16], new_px[23:16]),
                                    smooth8(old_px[15:8],  new_px[15:8]),
                                    smooth8(old_px[7:0],   new_px[7:0])};
        work_cnt_d[idx*CW +: CW] = smooth_cnt(old_c, new_c);
        if (bin_q == BW'(BIN_QTY-1)) state_d = S_PUBLISH;
        else                         bin_d   = bin_q + BW'(1);
      end
      S_PUBLISH: begin
        drop_d = inValid;
        // Outputs only move while the driver reports idle.
        if (ldDone) begin
          rgb_d   = work_rgb_q;
          cnt_d   = work_cnt_q;
          start_d = 1'b1;
          state_d = S_HANDOFF;
        end
      end
      S_HANDOFF: begin
        drop_d = inValid;
        if (!ldDone) begin
          start_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bin_q      <= '0;
      in_rgb_q   <= '0;
      in_cnt_q   <= '0;
      work_rgb_q <= '0;
      work_cnt_q <= '0;
      rgb_q      <= '0;
      cnt_q      <= '0;
      start_q    <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      in_rgb_q   <= in_rgb_d;
      in_cnt_q   <= in_cnt_d;
      work_rgb_q <= work_rgb_d;
      work_cnt_q <= work_cnt_d;
      rgb_q      <= rgb_d;
      cnt_q      <= cnt_d;
      start_q    <= start_d;
      drop_q     <= drop_d;
    end
  end

  assign rgb          = rgb_q;
  assign LEDCounts    = cnt_q;
  assign start        = start_q;
  assign frameDropped = drop_q;

endmodule

// File: tb/tb_led_frame_smoother.sv
// Directed bench for led_frame_smoother: frames and their smoothed expectations go through
// a scoreboard queue and are compared when the DUT raises start.
module tb_led_frame_smoother;
  localparam int BQ   = 12;
  localparam int LEDS = 50;
  localparam int SH   = 2;
  localparam int CW   = $clog2(LEDS);
  localparam int RW   = BQ*24;
  localparam int NW   = BQ*CW;

  logic          clk = 1'b0;
  logic          rst, inValid, ldDone;
  logic [RW-1:0] rgbIn, rgb;
  logic [NW-1:0] LEDCountsIn, LEDCounts;
  logic          start, frameDropped;

  led_frame_smoother #(.BIN_QTY(BQ), .LEDS(LEDS), .DECAY_SHIFT(SH)) dut (
    .clk(clk), .rst(rst), .rgbIn(rgbIn), .LEDCountsIn(LEDCountsIn), .inValid(inValid),
    .ldDone(ldDone), .rgb(rgb), .LEDCounts(LEDCounts), .start(start),
    .frameDropped(frameDropped));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [RW-1:0] c;
    logic [NW-1:0] n;
  } frame_t;

  frame_t        sb[$];
  logic [RW-1:0] hist_c;
  logic [NW-1:0] hist_n;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model(input int o, input int n);
    int s;
    if (n >= o) return n;
    s = (o - n) / (1 << SH);
    if (s < 1) s = 1;
    return o - s;
  endfunction

  task automatic send(input logic [RW-1:0] c, input logic [NW-1:0] n);
    frame_t f;
    @(negedge clk);
    rgbIn = c; LEDCountsIn = n; inValid = 1'b1;
    for (int b = 0; b < BQ; b++) begin
      for (int ch = 0; ch < 3; ch++)
        hist_c[b*24+ch*8 +: 8] = 8'(model(int'(hist_c[b*24+ch*8 +: 8]), int'(c[b*24+ch*8 +: 8])));
      hist_n[b*CW +: CW] = CW'(model(int'(hist_n[b*CW +: CW]), int'(n[b*CW +: CW])));
    end
    f.c = hist_c; f.n = hist_n;
    sb.push_back(f);
    @(negedge clk);
    inValid = 1'b0;
  endtask

  task automatic wait_pub(input int exp_lat, input string tag);
    int cyc = 1;
    frame_t f;
    while (start !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_start"}, RW'(start), RW'(1));
    if (exp_lat > 0) check({tag, "_latency"}, RW'(cyc), RW'(exp_lat));
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, RW'(0), RW'(1));
    end else begin
      f = sb.pop_front();
      check({tag, "_rgb"}, rgb, f.c);
      check({tag, "_cnt"}, RW'(LEDCounts), RW'(f.n));
    end
  endtask

  task automatic release_drv(input string tag);
    @(negedge clk);
    check({tag, "_held"}, RW'(start), RW'(1));
    ldDone = 1'b0;
    @(negedge clk);
    check({tag, "_drop_start"}, RW'(start), RW'(0));
    ldDone = 1'b1;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    hist_c = '0; hist_n = '0;
    sb.delete();
  endtask

  function automatic logic [RW-1:0] rand_rgb();
    logic [RW-1:0] v;
    for (int b = 0; b < BQ; b++) v[b*24 +: 24] = 24'($urandom);
    return v;
  endfunction

  function automatic logic [NW-1:0] rand_cnt();
    logic [NW-1:0] v;
    for (int b = 0; b < BQ; b++) v[b*CW +: CW] = CW'($urandom_range(0, LEDS-1));
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RW-1:0] c, prev;
    logic [NW-1:0] n;
    logic [7:0]    r_exp [3];
    logic          bad;
    rst = 1'b1; inValid = 1'b0; ldDone = 1'b1; rgbIn = '0; LEDCountsIn = '0;
    hist_c = '0; hist_n = '0;
    r_exp[0] = 8'h60; r_exp[1] = 8'h48; r_exp[2] = 8'h36;

    // Reset state
    do_reset(10);
    check("rst_rgb", rgb, '0);
    check("rst_cnt", RW'(LEDCounts), '0);
    check("rst_start", RW'(start), '0);
    check("rst_drop", RW'(frameDropped), '0);

    // Attack from reset, latency of BQ+2
    c = rand_rgb(); n = rand_cnt();
    c[23:0] = 24'h80FF10; n[CW-1:0] = CW'(10);
    send(c, n);
    wait_pub(BQ+2, "attack");
    check("attack_bin0_rgb", RW'(rgb[23:0]), RW'(24'h80FF10));
    check("attack_bin0_cnt", RW'(LEDCounts[CW-1:0]), RW'(10));
    release_drv("attack");

    // Decay toward zero with minimum step of 1
    do_reset(2);
    c = '0; n = '0;
    c[23:0] = 24'h800000; n[CW-1:0] = CW'(40);
    send(c, n);
    wait_pub(BQ+2, "decay_load");
    release_drv("decay_load");
    for (int k = 0; k < 24; k++) begin
      send('0, '0);
      wait_pub(BQ+2, "decay");
      if (k < 3) check("decay_R", RW'(rgb[23:16]), RW'(r_exp[k]));
      release_drv("decay");
    end
    check("decay_final_rgb", rgb, '0);
    check("decay_final_cnt", RW'(LEDCounts), '0);

    // Driver busy during PUBLISH: outputs and start frozen
    prev = rgb;
    @(negedge clk);
    ldDone = 1'b0;
    send(rand_rgb(), rand_cnt());
    bad = 1'b0;
    repeat (BQ + 50) begin
      @(negedge clk);
      if (start !== 1'b0 || rgb !== prev) bad = 1'b1;
    end
    check("busy_frozen", RW'(bad), '0);
    ldDone = 1'b1;
    @(negedge clk);
    check("busy_release_start", RW'(start), RW'(1));
    wait_pub(-1, "busy");
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (start !== 1'b1) bad = 1'b1;
    end
    check("busy_start_held", RW'(bad), '0);
    release_drv("busy");

    // Frames offered during FILTER and HANDOFF are dropped
    send(rand_rgb(), rand_cnt());
    @(negedge clk);
    rgbIn = rand_rgb(); LEDCountsIn = rand_cnt(); inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    check("drop_filter_pulse", RW'(frameDropped), RW'(1));
    @(negedge clk);
    check("drop_filter_clear", RW'(frameDropped), RW'(0));
    wait_pub(-1, "drop");
    @(negedge clk);
    rgbIn = rand_rgb(); LEDCountsIn = rand_cnt(); inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    check("drop_handoff_pulse", RW'(frameDropped), RW'(1));
    release_drv("drop");
    send(rand_rgb(), rand_cnt());
    check("idle_no_drop", RW'(frameDropped), RW'(0));
    wait_pub(BQ+2, "after_drop");
    release_drv("after_drop");

    // Reset in the middle of FILTER aborts the frame and clears history
    send(rand_rgb(), rand_cnt());
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hist_c = '0; hist_n = '0;
    sb.delete();
    check("midrst_rgb", rgb, '0);
    check("midrst_cnt", RW'(LEDCounts), '0);
    check("midrst_start", RW'(start), '0);
    bad = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (start !== 1'b0) bad = 1'b1;
    end
    check("midrst_no_start", RW'(bad), '0);
    send('0, '0);
    wait_pub(BQ+2, "midrst_hist");
    release_drv("midrst_hist");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
